// File: rtl/accelbrot_reg_master_pkg.sv
// Shared types for the accelbrot register-bus master.
//   BUFF_BASE_DEFAULT : first address of the variable-latency buffer region
//   rsp_t             : one response FIFO entry {data, error}
//   fsm_t             : master sequencing states
package accelbrot_pkg;

  localparam logic [15:0] BUFF_BASE_DEFAULT = 16'h4000;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } rsp_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_BUFF_WAIT,
    S_TMO_FLUSH
  } fsm_t;

endpackage

// File: rtl/accelbrot_reg_master_if.sv
// Register/buffer slave bus of the accelbrot engine (no waitrequest).
//   reg_address/reg_write/reg_writedata/reg_read : initiator -> slave
//   reg_readdata/reg_readdatavalid               : slave -> initiator
interface accelbrot_reg_master_if;

  logic [15:0] reg_address;
  logic        reg_write;
  logic [31:0] reg_writedata;
  logic        reg_read;
  logic [31:0] reg_readdata;
  logic        reg_readdatavalid;

  modport master (
    output reg_address, reg_write, reg_writedata, reg_read,
    input  reg_readdata, reg_readdatavalid
  );

  modport slave (
    input  reg_address, reg_write, reg_writedata, reg_read,
    output reg_readdata, reg_readdatavalid
  );

endinterface

// File: rtl/accelbrot_reg_master_rsp_fifo.sv
// First-word-fall-through response FIFO for accelbrot_reg_master.
//   clk, rst         : clock, synchronous active-high reset
//   push, push_data  : write one rsp_t entry
//   pop              : consume the head entry
//   head, valid      : head entry (zero when empty) and non-empty flag
//   count            : current occupancy
module accelbrot_regm_rsp_fifo
  import accelbrot_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  rsp_t                         push_data,
  input  logic                         pop,
  output rsp_t                         head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  rsp_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/accelbrot_reg_master.sv
// Bus initiator for the accelbrot register/buffer slave port.
// Converts a valid/ready command stream into single-beat bus cycles and
// returns read data in order on a valid/ready response stream.
//   clk, rst          : clock, synchronous active-high reset
//   cmd_*             : command stream (write flag, address, write data)
//   rsp_*             : read response stream (data, timeout error flag)
//   bus               : register bus, master side
//   busy              : reads outstanding or a beat on the bus
//   err_unexpected    : sticky, read data arrived with nothing outstanding
// Optional feature: define ACCELBROT_REGM_TIMEOUT_EN to enable read timeout
// with error completions after TIMEOUT_CYCLES.
module accelbrot_reg_master
  import accelbrot_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [15:0] BUFF_BASE       = BUFF_BASE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_address,
  input  logic [31:0] cmd_writedata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  accelbrot_reg_master_if.master bus,
  output logic        busy,
  output logic        err_unexpected
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  if (MAX_OUTSTANDING < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("accelbrot_reg_master: MAX_OUTSTANDING and TIMEOUT_CYCLES must be >= 2");
  end

  fsm_t          state;
  fsm_t          state_next;
  logic [CW-1:0] n_out;
  logic [CW-1:0] fifo_count;
  logic          credit_ok;
  logic          is_buff;
  logic          accept;
  logic          accept_read;
  logic          rdv;
  logic          rdv_ok;
  logic          push;
  rsp_t          push_data;
  rsp_t          head;
  logic          tmo_fire;

  assign rdv         = bus.reg_readdatavalid;
  assign rdv_ok      = rdv && (n_out != '0);
  assign is_buff     = (cmd_address >= BUFF_BASE);
  // Reads in flight plus unconsumed responses must leave a FIFO slot free.
  assign credit_ok   = ({1'b0, n_out} + {1'b0, fifo_count}) < (CW+1)'(MAX_OUTSTANDING);
  assign accept      = cmd_valid && cmd_ready;
  assign accept_read = accept && !cmd_write;

`ifdef ACCELBROT_REGM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic [CW-1:0] flush_left;

  assign tmo_fire = (state != S_TMO_FLUSH) && (n_out != '0) && !rdv &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt    <= '0;
      flush_left <= '0;
    end else begin
      if (n_out == '0 || rdv || tmo_fire) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + TW'(1);
      // Every abandoned read gets one error completion, one per cycle.
      if (tmo_fire)                  flush_left <= n_out;
      else if (state == S_TMO_FLUSH) flush_left <= flush_left - CW'(1);
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    push       = 1'b0;
    push_data  = '0;
    if (rdv_ok) begin
      push      = 1'b1;
      push_data = '{data: bus.reg_readdata, error: 1'b0};
    end
    unique case (state)
      S_RUN: begin
        // Buffer reads wait for an empty pipe so they cannot overtake
        // fixed-latency register reads.
        if (!tmo_fire)
          cmd_ready = cmd_write || (credit_ok && (!is_buff || n_out == '0));
        if (cmd_valid && cmd_ready && !cmd_write && is_buff)
          state_next = S_BUFF_WAIT;
        if (tmo_fire)
          state_next = S_TMO_FLUSH;
      end
      S_BUFF_WAIT: begin
        if (tmo_fire)    state_next = S_TMO_FLUSH;
        else if (rdv_ok) state_next = S_RUN;
      end
      S_TMO_FLUSH: begin
`ifdef ACCELBROT_REGM_TIMEOUT_EN
        push      = 1'b1;
        push_data = '{data: '0, error: 1'b1};
        if (flush_left == CW'(1)) state_next = S_RUN;
`else
        state_next = S_RUN;
`endif
      end
      default: state_next = S_RUN;
    endcase
    if (rst) cmd_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_RUN;
      n_out             <= '0;
      err_unexpected    <= 1'b0;
      bus.reg_address   <= '0;
      bus.reg_writedata <= '0;
      bus.reg_write     <= 1'b0;
      bus.reg_read      <= 1'b0;
    end else begin
      state <= state_next;
      if (tmo_fire) n_out <= '0;
      else          n_out <= n_out + CW'(accept_read) - CW'(rdv_ok);
      if (rdv && n_out == '0) err_unexpected <= 1'b1;
      bus.reg_write <= accept && cmd_write;
      bus.reg_read  <= accept_read;
      if (accept) begin
        bus.reg_address   <= cmd_address;
        bus.reg_writedata <= cmd_writedata;
      end
    end
  end

  accelbrot_regm_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_valid && rsp_ready),
    .head      (head),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );

  assign rsp_data  = head.data;
  assign rsp_error = head.error;
  assign busy      = (n_out != '0) || bus.reg_write || bus.reg_read;

endmodule

// File: tb/tb_accelbrot_reg_master.sv
// Directed bench for accelbrot_reg_master with a 2-cycle register slave,
// programmable buffer latency and an in-order response scoreboard.
module tb_accelbrot_reg_master;
  import accelbrot_pkg::*;

  localparam int unsigned MAXO = 4;
  localparam logic [15:0] BB   = 16'h4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_address;
  logic [31:0] cmd_writedata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        busy;
  logic        err_unexpected;

  accelbrot_reg_master_if bus ();

  accelbrot_reg_master #(
    .MAX_OUTSTANDING (MAXO),
    .BUFF_BASE       (BB),
    .TIMEOUT_CYCLES  (16)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_address    (cmd_address),
    .cmd_writedata  (cmd_writedata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_error      (rsp_error),
    .bus            (bus),
    .busy           (busy),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected-value model and scoreboard
  logic [31:0] model [logic [15:0]];
  rsp_t        sb [$];

  function automatic logic [31:0] exp_read(input logic [15:0] a);
    if (a >= BB)           return {16'hB0F0, a};
    if (model.exists(a))   return model[a];
    return {16'h5A5A, a};
  endfunction

  // Slave model: register reads return 2 cycles after the strobe,
  // buffer reads after buff_lat cycles; mute swallows reads.
  int   buff_lat    = 20;
  logic slave_mute  = 1'b0;
  int   inject_cnt  = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  initial begin
    logic [31:0] smem [logic [15:0]];
    ret_t        pend [$];
    int          scyc;
    int          inj_seen;
    logic [31:0] d;
    scyc = 0;
    inj_seen = 0;
    smem[16'h0000] = 32'h2307_2300;
    bus.reg_readdatavalid = 1'b0;
    bus.reg_readdata      = '0;
    forever begin
      @(negedge clk);
      scyc++;
      bus.reg_readdatavalid = 1'b0;
      bus.reg_readdata      = '0;
      if (inj_seen != inject_cnt) begin
        inj_seen = inject_cnt;
        bus.reg_readdatavalid = 1'b1;
        bus.reg_readdata      = 32'hDEAD_0000;
      end else if (pend.size() > 0 && pend[0].due == scyc) begin
        bus.reg_readdatavalid = 1'b1;
        bus.reg_readdata      = pend[0].data;
        void'(pend.pop_front());
      end
      if (bus.reg_write) smem[bus.reg_address] = bus.reg_writedata;
      if (bus.reg_read && !slave_mute) begin
        if (bus.reg_address >= BB)              d = {16'hB0F0, bus.reg_address};
        else if (smem.exists(bus.reg_address))  d = smem[bus.reg_address];
        else                                    d = {16'h5A5A, bus.reg_address};
        pend.push_back('{due: scyc + ((bus.reg_address >= BB) ? buff_lat : 2), data: d});
      end
    end
  end

  // Response monitor: samples just before the handshake edge.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rsp_valid && rsp_ready) begin
        last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_error", 32'(rsp_error), 32'(e.error));
        end
      end
    end
  end

  // Drive one command from a negedge; returns at the negedge after acceptance
  // (or after budget cycles without acceptance).
  task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input int budget, input logic tmo, output logic acc, output int acc_cyc);
    acc = 1'b0;
    acc_cyc = -1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_address = a;
    cmd_writedata = d;
    for (int i = 0; i < budget && !acc; i++) begin
      #4;
      if (cmd_ready) begin
        acc = 1'b1;
        if (w)        model[a] = d;
        else if (tmo) sb.push_back('{data: 32'd0, error: 1'b1});
        else          sb.push_back('{data: exp_read(a), error: 1'b0});
      end
      @(negedge clk);
    end
    if (acc) acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !rsp_valid;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   t0, t1;
    model[16'h0000] = 32'h2307_2300;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_address = '0;
    cmd_writedata = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_reg_write", 32'(bus.reg_write), 32'd0);
    check("rst_reg_read",  32'(bus.reg_read), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_err",       32'(err_unexpected), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // 1: write then read back
    send(1'b1, 16'h0430, 32'd640, 4, 1'b0, acc, t0);
    check("t1_wr_acc", 32'(acc), 32'd1);
    check("t1_reg_write", 32'(bus.reg_write), 32'd1);
    check("t1_reg_address", 32'(bus.reg_address), 32'h0430);
    check("t1_reg_writedata", bus.reg_writedata, 32'd640);
    @(negedge clk);
    check("t1_wr_pulse", 32'(bus.reg_write), 32'd0);
    send(1'b0, 16'h0430, 32'd0, 4, 1'b0, acc, t0);
    check("t1_rd_acc", 32'(acc), 32'd1);
    wait_drain("t1_drain", 20);

    // 2: credit limit with responses stalled
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 16'(16'h0100 + 4 * i), 32'd0, 4, 1'b0, acc, t0);
      check("t2_acc", 32'(acc), 32'd1);
    end
    send(1'b0, 16'h0110, 32'd0, 8, 1'b0, acc, t0);
    check("t2_5th_blocked", 32'(acc), 32'd0);
    check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    send(1'b0, 16'h0110, 32'd0, 20, 1'b0, acc, t0);
    check("t2_5th_acc", 32'(acc), 32'd1);
    wait_drain("t2_drain", 30);

    // 3: buffer read held behind a register read
    buff_lat = 20;
    send(1'b0, 16'h0000, 32'd0, 4, 1'b0, acc, t0);
    check("t3_reg_acc", 32'(acc), 32'd1);
    send(1'b0, 16'h4008, 32'd0, 10, 1'b0, acc, t1);
    check("t3_buf_acc", 32'(acc), 32'd1);
    check("t3_buf_hold", 32'(t1 - t0), 32'd4);
    send(1'b1, 16'h0010, 32'd7, 10, 1'b0, acc, t0);
    check("t3_wait_blocks", 32'(acc), 32'd0);
    wait_drain("t3_drain", 40);
    send(1'b1, 16'h0010, 32'd7, 4, 1'b0, acc, t0);
    check("t3_run_again", 32'(acc), 32'd1);
    repeat (2) @(negedge clk);

    // 4: unexpected read data while idle
    check("t4_pre_err", 32'(err_unexpected), 32'd0);
    inject_cnt++;
    repeat (3) @(negedge clk);
    check("t4_err", 32'(err_unexpected), 32'd1);
    check("t4_no_rsp", 32'(rsp_valid), 32'd0);
    repeat (10) @(negedge clk);
    check("t4_sticky", 32'(err_unexpected), 32'd1);

`ifdef ACCELBROT_REGM_TIMEOUT_EN
    // 5: buffer read that never returns
    slave_mute = 1'b1;
    send(1'b0, 16'h4000, 32'd0, 4, 1'b1, acc, t0);
    check("t5_acc", 32'(acc), 32'd1);
    wait_drain("t5_drain", 40);
    check("t5_tmo_window", 32'((last_rsp_cyc - t0 >= 16) && (last_rsp_cyc - t0 <= 18)), 32'd1);
    slave_mute = 1'b0;
    send(1'b0, 16'h0430, 32'd0, 4, 1'b0, acc, t0);
    check("t5_resume", 32'(acc), 32'd1);
    wait_drain("t5_resume_drain", 20);
`endif

    // 6: reset with two reads in flight
    send(1'b0, 16'h0020, 32'd0, 4, 1'b0, acc, t0);
    send(1'b0, 16'h0024, 32'd0, 4, 1'b0, acc, t0);
    check("t6_acc", 32'(acc), 32'd1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t6_reg_read", 32'(bus.reg_read), 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_err_clr", 32'(err_unexpected), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_late_rdv", 32'(err_unexpected), 32'd1);
    check("t6_fifo_empty", 32'(rsp_valid), 32'd0);
    send(1'b0, 16'h0430, 32'd0, 4, 1'b0, acc, t0);
    check("t6_fresh_acc", 32'(acc), 32'd1);
    wait_drain("t6_drain", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
